// File: rtl/md_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings,
// FSM state type and a constant-friendly ceiling-log2 helper.
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/md_abs.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to re-apply result signs.
module md_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO results and start/busy/done
// handshake. Define MD_EARLY_TERM_EN to end multiplies after the top set bit of |b|.
module mult_div_seq
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = clog2(WIDTH);

  md_state_t          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_res, r_neg_rem, r_dz;
  logic [2*WIDTH-1:0] r_acc;     // product accumulator, or remainder in [WIDTH:0]
  logic [2*WIDTH-1:0] r_mcand;   // shifted multiplicand, or divisor in [WIDTH-1:0]
  logic [WIDTH-1:0]   r_mplier;  // multiplier, or dividend shifting into quotient
  logic               r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_div, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH:0]     w_rem_sh, w_rem_next;
  logic [WIDTH+1:0]   w_diff;
  logic               w_q_bit;
  logic [CW-1:0]      w_cnt_load;

  assign w_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign w_signed = (op == MD_MULT) || (op == MD_DIV);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];

  md_abs #(.WIDTH(WIDTH)) u_abs_a (.i_val(a), .i_neg(w_a_neg), .o_val(w_abs_a));
  md_abs #(.WIDTH(WIDTH)) u_abs_b (.i_val(b), .i_neg(w_b_neg), .o_val(w_abs_b));

  md_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod_fix));
  md_abs #(.WIDTH(WIDTH)) u_fix_quo (.i_val(r_mplier), .i_neg(r_neg_res), .o_val(w_quo_fix));
  md_abs #(.WIDTH(WIDTH)) u_fix_rem (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_rem), .o_val(w_rem_fix));

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_rem_sh   = {r_acc[WIDTH-1:0], r_mplier[WIDTH-1]};
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_mcand[WIDTH-1:0]};
  assign w_q_bit    = ~w_diff[WIDTH+1];
  assign w_rem_next = w_q_bit ? w_diff[WIDTH:0] : w_rem_sh;

`ifdef MD_EARLY_TERM_EN
  logic [CW-1:0] w_msb;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise synthesis infers a latch.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_abs_b[i]) w_msb = CW'(i);
    end
  end

  assign w_cnt_load = w_div ? CW'(WIDTH-1) : w_msb;
`else
  assign w_cnt_load = CW'(WIDTH-1);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  // NOTE: datapath registers are reset along with control so outputs and
  // internal state are never X after reset, including a reset mid-operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_is_div   <= w_div;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_cnt      <= w_cnt_load;
            r_div_zero <= 1'b0;
            r_mcand    <= {{WIDTH{1'b0}}, (w_div ? w_abs_b : w_abs_a)};
            r_mplier   <= w_div ? w_abs_a : w_abs_b;
            if (w_div && (b == '0)) begin
              r_dz    <= 1'b1;
              r_acc   <= {{WIDTH{1'b0}}, a};
              r_state <= ST_FIX;
            end else begin
              r_dz    <= 1'b0;
              r_acc   <= '0;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (r_is_div) begin
            r_acc    <= {{(WIDTH-1){1'b0}}, w_rem_next};
            r_mplier <= {r_mplier[WIDTH-2:0], w_q_bit};
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
          if (r_cnt == '0) r_state <= ST_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          if (r_dz) begin
            r_hi       <= r_acc[WIDTH-1:0];
            r_lo       <= '1;
            r_div_zero <= 1'b1;
          end else if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule
